// File: rtl/dmem_lsu_pkg.sv
// Shared types for the data-memory load/store unit: widths, size codes,
// the registered request record and the request legality check.
package dmem_lsu_pkg;

  localparam int WORD = 32;
  localparam int ADDR = 16;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  // Only what later states need; the word address lives in mem_a.
  typedef struct packed {
    logic            we;
    size_e           size;
    logic            sgn;
    logic [1:0]      off;
    logic [WORD-1:0] wdata;
  } lsu_req_t;

  function automatic logic addr_err(input size_e size, input logic [31:0] addr);
    return (size == SZ_X) ||
           (size == SZ_H && addr[0]) ||
           (size == SZ_W && addr[1:0] != 2'b00) ||
           (addr[31:ADDR+2] != '0);
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// CPU-side request/response channel of the load/store unit.
interface dmem_lsu_if;
  import dmem_lsu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_signed;
  logic [31:0]     req_addr;
  logic [WORD-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [WORD-1:0] resp_rdata;
  logic            resp_err;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_lsu_align.sv
// Combinational lane logic: little-endian extract + extend for loads,
// byte-lane merge of right-aligned store data into the read word.
module dmem_lsu_align
  import dmem_lsu_pkg::*;
(
  input  size_e           size,
  input  logic            sgn,
  input  logic [1:0]      off,
  input  logic [WORD-1:0] mem_word,
  input  logic [WORD-1:0] wdata,
  output logic [WORD-1:0] ldata,
  output logic [WORD-1:0] mdata
);
  localparam int NUM_LANES = WORD / 8;

  logic [NUM_LANES-1:0][7:0] mem_l, rep_l, mrg_l;
  logic [NUM_LANES-1:0]      be;
  logic [WORD-1:0]           shifted;

  assign mem_l = mem_word;

  // Replicate store data across lanes so each lane picks the same slice.
  always_comb begin
    case (size)
      SZ_B:    rep_l = {NUM_LANES{wdata[7:0]}};
      SZ_H:    rep_l = {(NUM_LANES/2){wdata[15:0]}};
      default: rep_l = wdata;
    endcase
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    localparam logic [1:0] LANE = 2'(k);
    assign be[k] = (size == SZ_B) ? (off == LANE) :
                   (size == SZ_H) ? (off[1] == LANE[1]) : 1'b1;
    assign mrg_l[k] = be[k] ? rep_l[k] : mem_l[k];
  end

  assign mdata = mrg_l;

  always_comb begin
    case (size)
      SZ_B:    shifted = mem_word >> {off, 3'b000};
      SZ_H:    shifted = mem_word >> {off[1], 4'b0000};
      default: shifted = mem_word;
    endcase
  end

  always_comb begin
    case (size)
      SZ_B:    ldata = {{(WORD-8){sgn & shifted[7]}}, shifted[7:0]};
      SZ_H:    ldata = {{(WORD-16){sgn & shifted[15]}}, shifted[15:0]};
      default: ldata = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-addressed, one-cycle-latency data memory:
// alignment checks, sub-word loads with extension, read-modify-write stores.
module dmem_lsu
  import dmem_lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  dmem_lsu_if.slave       cpu,
  output logic [ADDR-1:0] mem_a,
  output logic            mem_w,
  output logic [WORD-1:0] mem_d,
  input  logic [WORD-1:0] mem_q
);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, RESP} state_e;

  state_e          state_q, state_d;
  lsu_req_t        req_q, req_d, req_in;
  logic [ADDR-1:0] mem_a_q, mem_a_d;
  logic            mem_w_q, mem_w_d;
  logic [WORD-1:0] mem_d_q, mem_d_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;
  logic [WORD-1:0] resp_rdata_q, resp_rdata_d;
  logic [WORD-1:0] ld_data, mrg_data;

  assign req_in = '{we:    cpu.req_we,
                    size:  size_e'(cpu.req_size),
                    sgn:   cpu.req_signed,
                    off:   cpu.req_addr[1:0],
                    wdata: cpu.req_wdata};

  dmem_lsu_align u_align (
    .size     (req_q.size),
    .sgn      (req_q.sgn),
    .off      (req_q.off),
    .mem_word (mem_q),
    .wdata    (req_q.wdata),
    .ldata    (ld_data),
    .mdata    (mrg_data)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    mem_a_d      = mem_a_q;
    mem_w_d      = 1'b0;
    mem_d_d      = mem_d_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: if (cpu.req_valid) begin
        req_d   = req_in;
        mem_a_d = cpu.req_addr[ADDR+1:2];
        if (addr_err(req_in.size, cpu.req_addr)) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = '0;
        end else if (req_in.we && req_in.size == SZ_W) begin
          state_d = WRITE;
          mem_w_d = 1'b1;
          mem_d_d = cpu.req_wdata;
        end else begin
          state_d = READ;
        end
      end
      READ: state_d = CAPTURE;
      // mem_q now holds the word addressed in READ.
      CAPTURE: if (req_q.we) begin
        state_d = WRITE;
        mem_w_d = 1'b1;
        mem_d_d = mrg_data;
      end else begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = ld_data;
      end
      WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      RESP: if (cpu.resp_ready) begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      mem_a_q      <= '0;
      mem_w_q      <= 1'b0;
      mem_d_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      mem_a_q      <= mem_a_d;
      mem_w_q      <= mem_w_d;
      mem_d_q      <= mem_d_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign cpu.req_ready  = (state_q == IDLE);
  assign cpu.resp_valid = resp_valid_q;
  assign cpu.resp_err   = resp_err_q;
  assign cpu.resp_rdata = resp_rdata_q;
  assign mem_a          = mem_a_q;
  assign mem_w          = mem_w_q;
  assign mem_d          = mem_d_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu against a behavioural word memory.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_lsu_if bus();
  logic [ADDR-1:0] mem_a;
  logic            mem_w;
  logic [WORD-1:0] mem_d, mem_q;
  logic [31:0]     mem [65536];

  dmem_lsu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cpu   (bus),
    .mem_a (mem_a),
    .mem_w (mem_w),
    .mem_d (mem_d),
    .mem_q (mem_q)
  );

  always @(posedge clk) begin
    if (mem_w) mem[mem_a] <= mem_d;
    mem_q <= mem[mem_a];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wcyc;
    logic [15:0] waddr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [int];
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] rd_ref(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
  endfunction

  task automatic model(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int          idx, bp;
    logic [31:0] w, sh;
    idx = int'(a[17:2]);
    bp  = int'(a[1:0]);
    w   = rd_ref(idx);
    sh  = w >> (8 * bp);
    e = '{rdata: 32'h0, err: 1'b0, lat: 0, wcyc: 0, waddr: a[17:2]};
    if (sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
        a[31:18] != 14'h0) begin
      e.err = 1'b1;
      e.lat = 1;
    end else if (!we) begin
      e.lat = 3;
      case (sz)
        2'b00:   e.rdata = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
        2'b01:   e.rdata = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
        default: e.rdata = w;
      endcase
    end else begin
      case (sz)
        2'b00:   w[8*bp +: 8]  = wd[7:0];
        2'b01:   w[8*bp +: 16] = wd[15:0];
        default: w = wd;
      endcase
      ref_mem[idx] = w;
      e.lat  = (sz == 2'b10) ? 2 : 4;
      e.wcyc = (sz == 2'b10) ? 1 : 3;
    end
    exp_q.push_back(e);
  endtask

  // Called at a negedge while the DUT is idle; returns just after the accept edge.
  task automatic drive(input logic we, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] a, input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = sz;
    bus.req_signed = sgn;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    int          lat, wcyc, wcnt;
    logic [15:0] wa;
    exp_t        e;
    lat = 0; wcyc = 0; wcnt = 0; wa = '0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (mem_w) begin wcnt++; wcyc = c; wa = mem_a; end
      if (bus.resp_valid) lat = c;
    end
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk("latency", 32'(lat), 32'(e.lat));
    chk("rdata", bus.resp_rdata, e.rdata);
    chk("err", 32'(bus.resp_err), 32'(e.err));
    chk("mem_w_cnt", 32'(wcnt), 32'(e.wcyc != 0));
    chk("mem_w_cyc", 32'(wcyc), 32'(e.wcyc));
    if (e.wcyc != 0) chk("mem_a", 32'(wa), 32'(e.waddr));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_rdata", bus.resp_rdata, e.rdata);
      chk("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("ready_after", 32'(bus.req_ready), 32'd1);
    chk("valid_after", 32'(bus.resp_valid), 32'd0);
  endtask

  task automatic op(input logic we, input logic [1:0] sz, input logic sgn,
                    input logic [31:0] a, input logic [31:0] wd, input int hold);
    model(we, sz, sgn, a, wd);
    drive(we, sz, sgn, a, wd);
    collect(hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int act;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;

    // Reset state, with a request offered that must be ignored.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h12345678;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_mem_a", 32'(mem_a), 32'h0);
    chk("rst_mem_w", 32'(mem_w), 32'd0);
    chk("rst_mem_d", mem_d, 32'h0);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    op(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0);
    op(0, 2'b10, 0, 32'h10, 32'h0, 0);
    op(1, 2'b00, 0, 32'h12, 32'h00000055, 0);
    op(0, 2'b10, 0, 32'h10, 32'h0, 0);
    op(0, 2'b00, 1, 32'h13, 32'h0, 0);
    op(0, 2'b00, 0, 32'h13, 32'h0, 0);
    op(0, 2'b01, 1, 32'h10, 32'h0, 0);

    // Error requests: no memory access, memory word unchanged.
    op(0, 2'b01, 0, 32'h11, 32'h0, 0);
    op(1, 2'b10, 0, 32'h12, 32'hCAFEF00D, 0);
    op(0, 2'b11, 0, 32'h10, 32'h0, 0);
    op(0, 2'b10, 0, 32'h00040000, 32'h0, 0);
    op(0, 2'b10, 0, 32'h10, 32'h0, 0);
    chk("mem_word_after_err", mem[4], 32'hDE55BEEF);

    // Consumer back-pressure.
    bus.resp_ready = 1'b0;
    op(0, 2'b01, 0, 32'h12, 32'h0, 5);

    // Reset during the CAPTURE cycle of a byte store drops it.
    drive(1, 2'b00, 0, 32'h12, 32'h000000AA);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("mid_rst_mem_w", 32'(mem_w), 32'd0);
    chk("mid_rst_mem_a", 32'(mem_a), 32'h0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_w || bus.resp_valid) act++;
    end
    chk("mid_rst_activity", 32'(act), 32'd0);
    chk("mid_rst_req_ready2", 32'(bus.req_ready), 32'd1);
    chk("mid_rst_mem_word", mem[4], 32'hDE55BEEF);
    op(0, 2'b10, 0, 32'h10, 32'h0, 0);

    // Randomised mix over a small, fully initialised window.
    for (int i = 0; i < 16; i++) op(1, 2'b10, 0, 32'(i * 4), $urandom, 0);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | 32'h00040000;
      op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
         a, $urandom, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit that is the requesting end of the data-memory port: it accepts byte-addressed CPU load/store requests and drives the word-addressed, single-port, one-cycle-read-latency data memory (`dmem32x64k`). It performs alignment checking, sub-word lane extraction with sign/zero extension, and read-modify-write for byte and halfword stores. It sits between the core's MEM stage and the data memory.

## Interface
- `WORD`, 32 (from `params.vh`): data width.
- `ADDR`, 16 (from `params.vh`): memory word-address width; byte address space is `ADDR+2` bits.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  LSU can accept; a request is accepted on a rising edge with `req_valid && req_ready`.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_signed`  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  `WORD`  store data, right-aligned (bits [7:0] for byte, [15:0] for half).
- `resp_valid`  out  1  response present; held until `resp_ready`.
- `resp_ready`  in  1  CPU takes response.
- `resp_rdata`  out  `WORD`  load data, extended; 0 for stores and errors.
- `resp_err`  out  1  request was misaligned, out of range, or illegal size.
- `mem_a`  out  `ADDR`  memory word address (registered).
- `mem_w`  out  1  memory write enable (registered).
- `mem_d`  out  `WORD`  memory write data (registered).
- `mem_q`  in  `WORD`  memory read data, valid the cycle after a read address is presented.

## Operation
- States: IDLE, READ, CAPTURE, WRITE, RESP. `req_ready` = (state == IDLE).
- Accept in IDLE: register request; `mem_a <= req_addr[ADDR+1:2]`.
- Error check at accept: half with `addr[0]`=1, word with `addr[1:0]`!=0, `req_size`=11, or any of `req_addr[31:ADDR+2]` nonzero -> RESP with `resp_err`=1, no memory access (`mem_w` stays 0).
- Load: IDLE -> READ (`mem_w`=0) -> CAPTURE (sample `mem_q`, extract lane, extend) -> RESP.
- Word store: IDLE -> WRITE (`mem_w`=1, `mem_d`=`req_wdata`) -> RESP.
- Byte/half store: IDLE -> READ -> CAPTURE (merge `req_wdata` into `mem_q` lane) -> WRITE -> RESP.
- Lanes little-endian: byte k = bits [8k+7:8k], k = `addr[1:0]`; half lane = `addr[1]`.
- RESP: `resp_valid`=1, outputs stable until `resp_ready`=1 on an edge -> IDLE. A new request is accepted no earlier than the cycle after RESP exits.
- `mem_w` is 1 only in WRITE, exactly one cycle per store.

## Timing
- Accept edge = edge 0. Load/sub-word timing counted in cycles after it.
- Load: `resp_valid` in cycle 3. Word store: cycle 2. Sub-word store: `mem_w` in cycle 3, `resp_valid` cycle 4. Error: cycle 1.
- Reset values: state IDLE, `req_ready`=1 (requests ignored while `rst_n`=0), `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_a`=0, `mem_w`=0, `mem_d`=0.
- Reset mid-operation: all outputs go to reset values asynchronously; an in-flight store that has not reached its WRITE edge is dropped; no response is issued.
- `resp_ready` held high in RESP: one-cycle RESP, then IDLE.

## Structure
- `params.vh` gains size codes `SZ_B`, `SZ_H`, `SZ_W`; the state encoding is local to the module.
- One sub-module: `dmem_lsu_align`, purely combinational: lane extract + extend for loads, lane merge for stores.

## Test plan
- Word store 0xDEADBEEF to byte address 0x0010, then word load -> `mem_a`=0x0004, `mem_w` one cycle; load `resp_rdata`=0xDEADBEEF in cycle 3.
- After the above, byte store 0x55 to 0x0012, then word load -> 0xDE55BEEF; `mem_w` asserted only in cycle 3 of the store.
- Byte loads from 0x0013, signed and unsigned -> 0xFFFFFFDE and 0x000000DE; half load signed from 0x0010 -> 0xFFFFBEEF.
- Half load at 0x0011, word store at 0x0012, size=11, address 0x00040000 -> `resp_err`=1 in cycle 1, `mem_w` never asserted, memory unchanged.
- `resp_ready` held low 5 cycles -> `resp_valid` and `resp_rdata` stable, `req_ready`=0 throughout; accepted next request only after release.
- `rst_n` pulsed low in cycle 2 of a byte store -> no `mem_w`, no response, memory word unchanged, `req_ready`=1 after release.
